// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with a registered one-hot grant, an optional
// hold limit that forces a release, and a mandatory idle cycle between owners.
module arb4_rr #(
    parameter int MAXHOLD = 16,
    parameter int CNTW    = 5
) (
    input  logic       CK,
    input  logic       RSTN,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [3:0] GNT,
    output logic [1:0] GID,
    output logic       BUSY,
    output logic       TOUT
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic            HOLD_EN  = (MAXHOLD != 0);
    localparam logic [CNTW-1:0] HOLD_LIM = CNTW'(MAXHOLD);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [1:0]      last, last_nxt;
    logic [1:0]      gid_nxt;
    logic [3:0]      gnt_nxt;
    logic            busy_nxt;
    logic            tout_nxt;
    logic [1:0]      win;
    logic            rel_norm;
    logic            rel_force;

    // First set request found scanning upward from the slot after the last owner.
    function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] prev);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = prev;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = prev + 2'(i);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign win       = pick_winner(REQ, last);
    assign rel_norm  = DONE || !REQ[GID];
    assign rel_force = HOLD_EN && (cnt == HOLD_LIM);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        gid_nxt   = GID;
        gnt_nxt   = GNT;
        tout_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                gnt_nxt = 4'b0000;
                if (REQ != 4'b0000) begin
                    state_nxt = OWN;
                    gid_nxt   = win;
                    gnt_nxt   = 4'b0001 << win;
                    cnt_nxt   = CNTW'(1);
                end
            end
            OWN: begin
                if (rel_norm || rel_force) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    last_nxt  = GID;
                    cnt_nxt   = '0;
                    // An ordinary release on the expiry edge suppresses the timeout pulse.
                    tout_nxt  = !rel_norm;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == OWN);
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 2'd3;
            GID   <= 2'd0;
            GNT   <= 4'b0000;
            BUSY  <= 1'b0;
            TOUT  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
            GID   <= gid_nxt;
            GNT   <= gnt_nxt;
            BUSY  <= busy_nxt;
            TOUT  <= tout_nxt;
        end
    end

endmodule

// File: tb/tb_arb4_rr.sv
// Directed bench for arb4_rr: a per-cycle vector table plus a hand-written
// asynchronous-reset sequence.
module tb_arb4_rr;

    logic       CK;
    logic       RSTN;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic [1:0] GID;
    logic       BUSY;
    logic       TOUT;

    int n_chk;
    int n_pass;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] gid;
        logic       busy;
        logic       tout;
    } vec_t;

    vec_t vecs[$];

    arb4_rr #(.MAXHOLD(4), .CNTW(5)) dut (
        .CK   (CK),
        .RSTN (RSTN),
        .REQ  (REQ),
        .DONE (DONE),
        .GNT  (GNT),
        .GID  (GID),
        .BUSY (BUSY),
        .TOUT (TOUT)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic t);
        check({tag, ".gnt"},  8'(GNT),  8'(g));
        check({tag, ".gid"},  8'(GID),  8'(id));
        check({tag, ".busy"}, 8'(BUSY), 8'(b));
        check({tag, ".tout"}, 8'(TOUT), 8'(t));
    endtask

    function automatic vec_t mk(input logic [3:0] req, input logic done, input logic [3:0] gnt,
                                input logic [1:0] gid, input logic busy, input logic tout);
        vec_t v;
        v.req  = req;
        v.done = done;
        v.gnt  = gnt;
        v.gid  = gid;
        v.busy = busy;
        v.tout = tout;
        return v;
    endfunction

    initial begin
        n_chk  = 0;
        n_pass = 0;

        // Single requester, then DONE release (LAST starts at 3).
        vecs.push_back(mk(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        // All requesting, DONE every grant: rotation 1,2,3,0 with idle gaps.
        vecs.push_back(mk(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        // Hold limit 4: four grant cycles, timeout pulse with GNT low, re-grant.
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1));
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        // DONE on the expiry edge: ordinary release, no timeout.
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));
        // Owner 1 drops its request while 3 and 0 wait: next grant is 3.
        vecs.push_back(mk(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1001, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0));

        RSTN = 1'b0;
        REQ  = 4'b0000;
        DONE = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge CK);
        RSTN = 1'b1;

        foreach (vecs[i]) begin
            REQ  = vecs[i].req;
            DONE = vecs[i].done;
            @(posedge CK);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].gid, vecs[i].busy, vecs[i].tout);
            @(negedge CK);
        end

        // Asynchronous reset between edges aborts the grant and restores LAST=3.
        REQ  = 4'b0100;
        DONE = 1'b0;
        @(posedge CK);
        #1;
        check_all("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        RSTN = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge CK);
        RSTN = 1'b1;
        REQ  = 4'b1001;
        @(posedge CK);
        #1;
        check_all("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
        @(negedge CK);
        REQ  = 4'b0000;
        DONE = 1'b1;
        @(posedge CK);
        #1;
        check_all("post_rst_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-requester round-robin arbiter that shares a single downstream resource among up to four requesters. The block accepts level requests, issues one registered one-hot grant at a time, holds it until the owner releases it or a hold limit expires, and rotates priority so every requester is served. It is a synchronous controller cell in the ECP simulation cell set and uses the same upper-case port style as the rest of that set.

## Interface
- MAXHOLD, 16: maximum number of cycles a grant may be held before it is forcibly released. 0 = unlimited. Legal range 0..2^CNTW-1.
- CNTW, 5: width of the hold counter.
- CK  in  1  clock, rising-edge active
- RSTN  in  1  reset; one clock; reset is asynchronous and active-low
- REQ  in  4  level request per requester; bit i = requester i
- DONE  in  1  the current owner releases the grant; ignored while no grant is active
- GNT  out  4  registered one-hot grant, or all zero
- GID  out  2  binary index of the current or most recent owner
- BUSY  out  1  high while any GNT bit is high
- TOUT  out  1  one-cycle pulse indicating a forced release on hold expiry

## Operation
- State machine has two states:
  - IDLE: GNT=0. If REQ≠0 at a clock edge, move to OWN and grant the winner.
  - OWN: exactly one GNT bit is high.
- Winner selection: search starting at LAST+1 mod 4, ascending with wrap; the first set REQ bit wins. LAST is the index of the most recent owner.
- GID is loaded with the winner index when entering OWN. GID and LAST keep that value after release.
- Release conditions while in OWN, evaluated at every edge:
  - (a) DONE=1.
  - (b) REQ[GID]=0, i.e. the owner drops its request.
  - (c) MAXHOLD≠0, hold count == MAXHOLD, and neither (a) nor (b) is true. This is a forced release: TOUT=1 for the following cycle only.
- On any release: go to IDLE, GNT=0, and set LAST=GID.
- Priority when release conditions coincide:
  - (a) and (b) override (c). No TOUT is generated.
  - DONE and the owner's REQ drop on the same edge count as one ordinary release.
- Hold counter:
  - Loaded with 1 on entry to OWN.
  - Increments each cycle in OWN.
  - Saturates at 2^CNTW-1.
  - Cleared in IDLE.
- No handoff from one owner directly to another. After every release there is exactly one IDLE cycle with GNT=0.
- REQ changes of non-owners while in OWN have no effect until the next arbitration.
- Reset (RSTN=0) takes effect immediately, without waiting for a clock edge:
  - GNT=0000, GID=0, BUSY=0, TOUT=0, state=IDLE, counter=0, LAST=3. LAST=3 means requester 0 has first priority after reset.
  - Assertion during OWN aborts the grant at once. No TOUT is generated.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Grant latency: REQ is sampled high at edge n while in IDLE, and GNT/BUSY/GID are valid after edge n. That is one cycle from request to grant.
- Release latency:
  - DONE is sampled at edge m; GNT=0 after edge m.
  - The earliest next grant is after edge m+1.
  - Minimum turnaround is therefore 2 cycles.
- Forced release: with MAXHOLD=H, the grant lasts exactly H cycles. GNT=0 and TOUT=1 occur after the edge that ends cycle H. TOUT drops after the next edge.
- The first edge after RSTN deasserts may arbitrate normally.

## Test plan
- Reset, then REQ=0001 → GNT=0001 after 1 edge, GID=0, BUSY=1. DONE pulse → GNT=0000 next cycle, BUSY=0.
- REQ=1111 held constant, DONE pulsed every grant → grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
- MAXHOLD=4, REQ=0100 held, DONE never asserted:
  - GNT=0100 for exactly 4 cycles, then TOUT=1 for 1 cycle with GNT=0000.
  - Re-grant 0100 on the following cycle.
- MAXHOLD=4, DONE asserted on the same edge that hold count reaches 4 → ordinary release, TOUT stays 0.
- Owner 1 drops REQ[1] while REQ=1011 → release without TOUT; next grant goes to requester 3 (search from 2), not requester 0.
- RSTN pulled low mid-grant, between clock edges → GNT=0000 immediately. After release of reset, REQ=1001 → GNT=0001 (LAST reset to 3).
